// File: rtl/gemm_tile_sequencer.sv
// Tile-loop sequencer for the systolic GEMM datapath: walks an M x N x K tile
// space (m outer, k inner), issuing loads, PE-array runs and one C store per (m,n).
module gemm_tile_sequencer #(
  parameter int IDX_W = 16,
  parameter int CNT_W = 2 * IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] cfg_m_tiles,
  input  logic [IDX_W-1:0] cfg_n_tiles,
  input  logic [IDX_W-1:0] cfg_k_tiles,
  input  logic             abort,
  output logic             load_valid,
  input  logic             load_ready,
  output logic [IDX_W-1:0] load_m,
  output logic [IDX_W-1:0] load_n,
  output logic [IDX_W-1:0] load_k,
  output logic             comp_start,
  output logic             comp_acc,
  input  logic             comp_done,
  output logic             store_valid,
  input  logic             store_ready,
  output logic [IDX_W-1:0] store_m,
  output logic [IDX_W-1:0] store_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tiles_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_WAIT,
    S_STORE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] m_idx;
  logic [IDX_W-1:0] n_idx;
  logic [IDX_W-1:0] k_idx;
  logic [IDX_W-1:0] m_cfg;
  logic [IDX_W-1:0] n_cfg;
  logic [IDX_W-1:0] k_cfg;
  logic [CNT_W-1:0] store_cnt;
  logic             m_last;
  logic             n_last;
  logic             k_last;
  logic             cfg_zero;
  logic             accept;
  logic             advance;
  logic             count_store;

  assign m_last   = (m_idx == m_cfg - IDX_W'(1));
  assign n_last   = (n_idx == n_cfg - IDX_W'(1));
  assign k_last   = (k_idx == k_cfg - IDX_W'(1));
  assign cfg_zero = (cfg_m_tiles == '0) || (cfg_n_tiles == '0) || (cfg_k_tiles == '0);

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    advance     = 1'b0;
    count_store = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = cfg_zero ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_ready) state_nx = S_COMPUTE;
      end
      S_COMPUTE: state_nx = S_WAIT;
      S_WAIT: begin
        if (comp_done) state_nx = k_last ? S_STORE : S_NEXT;
      end
      S_STORE: begin
        if (store_ready) begin
          count_store = 1'b1;
          state_nx    = S_NEXT;
        end
      end
      S_NEXT: begin
        if (m_last && n_last && k_last) begin
          state_nx = S_DONE;
        end else begin
          advance  = 1'b1;
          state_nx = S_LOAD;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Abort overrides any handshake completing in the same cycle.
    if (abort && (state != S_IDLE)) begin
      state_nx    = S_IDLE;
      advance     = 1'b0;
      count_store = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      m_idx     <= '0;
      n_idx     <= '0;
      k_idx     <= '0;
      m_cfg     <= '0;
      n_cfg     <= '0;
      k_cfg     <= '0;
      store_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        m_cfg     <= cfg_m_tiles;
        n_cfg     <= cfg_n_tiles;
        k_cfg     <= cfg_k_tiles;
        m_idx     <= '0;
        n_idx     <= '0;
        k_idx     <= '0;
        store_cnt <= '0;
      end
      if (count_store) store_cnt <= store_cnt + CNT_W'(1);
      // k wraps into n, n wraps into m.
      if (advance) begin
        if (k_last) begin
          k_idx <= '0;
          if (n_last) begin
            n_idx <= '0;
            m_idx <= m_idx + IDX_W'(1);
          end else begin
            n_idx <= n_idx + IDX_W'(1);
          end
        end else begin
          k_idx <= k_idx + IDX_W'(1);
        end
      end
    end
  end

  assign load_valid  = (state == S_LOAD);
  assign load_m      = m_idx;
  assign load_n      = n_idx;
  assign load_k      = k_idx;
  assign comp_start  = (state == S_COMPUTE);
  assign comp_acc    = ((state == S_COMPUTE) || (state == S_WAIT)) && (k_idx != '0);
  assign store_valid = (state == S_STORE);
  assign store_m     = m_idx;
  assign store_n     = n_idx;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign tiles_done  = store_cnt;

endmodule

// File: doc/gemm_tile_sequencer.md
# gemm_tile_sequencer

Parametrised tile-loop sequencer for the systolic-array GEMM datapath. It walks a runtime-configured M×N×K tile space in m-outer, n-middle, k-inner order. For each step it issues A/B tile-load requests, starts and awaits the PE array with an accumulate flag, and issues one C-tile store per (m,n) after the last k. All external exchanges use valid/ready or start/done handshakes, so the sequencer tolerates arbitrary memory and compute latency.

## Interface
- IDX_W, 16, width of each tile index and tile-count field
- CNT_W, 2*IDX_W, width of the stored-tile counter

- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a job; honoured only in IDLE
- cfg_m_tiles / cfg_n_tiles / cfg_k_tiles  in  IDX_W each  tile counts, latched on accepted start
- abort  in  1  cancel current job
- load_valid  out  1  A/B tile load request
- load_ready  in  1  load accepted when valid&ready
- load_m / load_n / load_k  out  IDX_W each  tile indices of the load
- comp_start  out  1  one-cycle PE-array start pulse
- comp_acc  out  1  1 = accumulate into PE partial sums (k>0); 0 = clear first
- comp_done  in  1  PE array finished current tile
- store_valid  out  1  C tile store request
- store_ready  in  1  store accepted when valid&ready
- store_m / store_n  out  IDX_W each  C tile indices
- busy  out  1  state != IDLE
- done  out  1  one-cycle job-complete pulse
- tiles_done  out  CNT_W  number of C stores fired in current/last job

## Operation
- States: IDLE, LOAD, COMPUTE, WAIT, STORE, NEXT, DONE.
- IDLE: start=1 latches cfg_*, clears m/n/k and tiles_done. If any cfg field is 0, go to DONE; otherwise go to LOAD. start in any other state is ignored.
- LOAD: load_valid=1 with indices (m,n,k) held stable. On fire, go to COMPUTE.
- COMPUTE: comp_start=1 for exactly one cycle; comp_acc=(k!=0), held through WAIT. Go to WAIT.
- WAIT: on comp_done=1, go to STORE if k==K-1, else to NEXT. comp_done is sampled only in WAIT.
- STORE: store_valid=1 with (m,n). On fire, tiles_done+=1 and go to NEXT.
- NEXT: if m==M-1, n==N-1 and k==K-1, go to DONE.
  - Otherwise advance k; on k wrap to 0, advance n; on n wrap to 0, advance m. Then go to LOAD.
- DONE: done=1 for one cycle, then go to IDLE.
- abort=1 in any non-IDLE state goes to IDLE next cycle.
  - All valids drop; no done pulse; tiles_done holds.
  - abort has priority over any handshake fire in the same cycle; that transfer does not count.
- Counter arithmetic is unsigned. tiles_done cannot overflow, since M·N < 2^CNT_W.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE. load_valid, store_valid, comp_start, comp_acc, busy, done=0. tiles_done, all index outputs and internal m/n/k=0.
- Reset mid-job behaves like abort plus clearing tiles_done. It takes effect on the next edge.
- Start accepted at edge T gives busy=1 and load_valid=1 from T+1.
- Minimum per-tile cost with ready tied high and comp_done one cycle after comp_start:
  - non-last k: LOAD, COMPUTE, WAIT, NEXT = 4 cycles;
  - last k: 5 cycles, adding STORE.
- 1×1×1 job, start at T:
  - LOAD T+1, COMPUTE T+2, WAIT T+3 (comp_done), STORE T+4, NEXT T+5;
  - done pulse T+6, busy=0 at T+7.
- Zero-count job: done pulse at T+1, busy=0 at T+2, no load or store.
- Valids stay high until fire (or abort). Indices must not change while valid=1.
- comp_done asserted outside WAIT is ignored. The PE array must hold comp_done until WAIT, or assert it only after comp_start.
- start and abort in the same IDLE cycle: start wins, because abort has no effect in IDLE.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs → every output 0. After release, busy stays 0 until start.
- Full walk, M=2 N=2 K=3, ready high, comp_done one cycle after comp_start:
  - 12 loads in order (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(1,1,2);
  - comp_acc pattern 0,1,1 repeated;
  - stores (0,0),(0,1),(1,0),(1,1) each after k=2;
  - tiles_done=4, exactly one done pulse.
- 1×1×1 latency check: done exactly at T+6 and busy falling at T+7. Also cfg_k_tiles=0 → done at T+1 with no load_valid or store_valid ever high.
- Backpressure:
  - hold load_ready low 5 cycles → load_valid and indices stable, no comp_start;
  - randomise store_ready and comp_done delay (0–20 cycles) → same transaction sequence as the unstalled run.
- Abort in WAIT during tile (1,0,1) of a 2×2×2 job → IDLE next cycle, no done, tiles_done=2. A new start with 1×1×1 then completes normally with tiles_done=1.
- start pulsed while busy and cfg changed mid-job → ignored. The job uses the latched counts and produces exactly M·N stores.
